// File: rtl/cont1_monitor.sv
// Lock-and-track monitor for a WIDTH-bit triangle counter (0..MAX..0).
// Acquires lock after LOCK_N consistent +/-1 steps, then flags deviations and counts periods.
module cont1_monitor #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] sa,
    input  logic             clear,
    output logic             dir,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             at_top,
    output logic             at_bottom
);

    localparam int STEP_W = $clog2(LOCK_N + 1);
    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  prev, prev_nxt;
    logic [STEP_W-1:0] step, step_nxt, step_inc;
    logic              dir_nxt, err_nxt, top_nxt, bot_nxt;
    logic              ecnt_inc, pcnt_inc;
    logic              is_up, is_dn, endpoint, acq_ok;
    logic [WIDTH-1:0]  expect_val;
    logic              expect_dir;

    always_comb begin
        is_up    = (prev != MAX) && (sa == prev + ONE);
        is_dn    = (prev != '0)  && (sa == prev - ONE);
        endpoint = ((prev == MAX) && (sa == MAX - ONE)) || ((prev == '0) && (sa == ONE));
        // The first step of an acquisition may go either way; later ones must keep direction
        // unless they are the reversal at an endpoint.
        acq_ok   = (is_up || is_dn) && ((step == '0) || (is_dn == dir) || endpoint);
        step_inc = step + STEP_W'(1);

        if (!dir) begin
            expect_val = (prev == MAX) ? MAX - ONE : prev + ONE;
            expect_dir = (prev == MAX);
        end else begin
            expect_val = (prev == '0) ? ONE : prev - ONE;
            expect_dir = (prev != '0);
        end
    end

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        step_nxt  = step;
        dir_nxt   = dir;
        err_nxt   = 1'b0;
        top_nxt   = 1'b0;
        bot_nxt   = 1'b0;
        ecnt_inc  = 1'b0;
        pcnt_inc  = 1'b0;
        if (en) begin
            case (state)
                HUNT: begin
                    prev_nxt  = sa;
                    step_nxt  = '0;
                    state_nxt = ACQ;
                end
                ACQ: begin
                    prev_nxt = sa;
                    if (acq_ok) begin
                        dir_nxt  = is_dn;
                        step_nxt = step_inc;
                        if (step_inc == STEP_W'(LOCK_N))
                            state_nxt = LOCKED;
                    end else begin
                        step_nxt = '0;
                    end
                end
                LOCKED: begin
                    prev_nxt = sa;
                    if (sa == expect_val) begin
                        dir_nxt  = expect_dir;
                        top_nxt  = (sa == MAX);
                        bot_nxt  = (sa == '0);
                        pcnt_inc = (sa == '0);
                    end else begin
                        err_nxt   = 1'b1;
                        ecnt_inc  = 1'b1;
                        step_nxt  = '0;
                        state_nxt = ACQ;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HUNT;
            prev       <= '0;
            step       <= '0;
            dir        <= 1'b0;
            err        <= 1'b0;
            at_top     <= 1'b0;
            at_bottom  <= 1'b0;
            err_cnt    <= '0;
            period_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            step      <= step_nxt;
            dir       <= dir_nxt;
            err       <= err_nxt;
            at_top    <= top_nxt;
            at_bottom <= bot_nxt;
            if (clear) begin
                err_cnt    <= '0;
                period_cnt <= '0;
            end else begin
                if (ecnt_inc && (err_cnt != '1))
                    err_cnt <= err_cnt + CNT_W'(1);
                if (pcnt_inc)
                    period_cnt <= period_cnt + CNT_W'(1);
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_cont1_monitor.sv
// Directed bench for cont1_monitor: stimulus pushes hand-computed expectations, a monitor
// process pops one per clock and compares; a negative expected field means "don't care".
module tb_cont1_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [3:0] sa    = '0;
    logic       clear = 1'b0;
    logic       dir, locked, err, at_top, at_bottom;
    logic [7:0] err_cnt, period_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int xl, xd, xe, xt, xb, xec, xpc;
    } exp_t;

    exp_t exp_q[$];

    cont1_monitor #(.WIDTH(4), .CNT_W(8), .LOCK_N(3)) dut (
        .clock(clock), .reset(reset), .en(en), .sa(sa), .clear(clear),
        .dir(dir), .locked(locked), .err(err), .err_cnt(err_cnt),
        .period_cnt(period_cnt), .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int want);
        if (want >= 0) begin
            checks++;
            if (act != want) begin
                errors++;
                $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, want);
            end
        end
    endtask

    // Monitor: each captured cycle yields exactly one queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("locked",     int'(locked),     x.xl);
                chk("dir",        int'(dir),        x.xd);
                chk("err",        int'(err),        x.xe);
                chk("at_top",     int'(at_top),     x.xt);
                chk("at_bottom",  int'(at_bottom),  x.xb);
                chk("err_cnt",    int'(err_cnt),    x.xec);
                chk("period_cnt", int'(period_cnt), x.xpc);
            end
        end
    end

    task automatic drv(input bit r, input bit e, input bit c, input int s,
                       input int xl, input int xd, input int xe, input int xt,
                       input int xb, input int xec, input int xpc);
        exp_t x;
        @(negedge clock);
        reset = r;
        en    = e;
        clear = c;
        sa    = 4'(s);
        x.xl = xl; x.xd = xd; x.xe = xe; x.xt = xt; x.xb = xb; x.xec = xec; x.xpc = xpc;
        exp_q.push_back(x);
    endtask

    task automatic smp(input int s, input int xl, input int xd, input int xe, input int xt,
                       input int xb, input int xec, input int xpc);
        drv(1'b0, 1'b1, 1'b0, s, xl, xd, xe, xt, xb, xec, xpc);
    endtask

    task automatic gap(input int s, input int xl, input int xd, input int xec, input int xpc);
        drv(1'b0, 1'b0, 1'b0, s, xl, xd, 0, 0, 0, xec, xpc);
    endtask

    initial begin
        // reset state
        drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

        // acquisition 0,1,2,3 then tracking at 4
        smp(0, 0, 0, 0, 0, 0, 0, 0);
        smp(1, 0, 0, 0, 0, 0, 0, 0);
        smp(2, 0, 0, 0, 0, 0, 0, 0);
        smp(3, 1, 0, 0, 0, 0, 0, 0);
        smp(4, 1, 0, 0, 0, 0, 0, 0);
        smp(5, 1, 0, 0, 0, 0, 0, 0);
        smp(6, 1, 0, 0, 0, 0, 0, 0);
        gap(9, 1, 0, 0, 0);
        gap(7, 1, 0, 0, 0);
        for (int v = 7; v <= 14; v++) smp(v, 1, 0, 0, 0, 0, 0, 0);
        smp(15, 1, -1, 0, 1, 0, 0, 0);
        gap(3, 1, -1, 0, 0);
        for (int v = 14; v >= 1; v--) smp(v, 1, 1, 0, 0, 0, 0, 0);
        smp(0, 1, -1, 0, 0, 1, 0, 1);
        gap(0, 1, -1, 0, 1);
        smp(1, 1, 0, 0, 0, 0, 0, 1);

        // skip a value while locked ascending, then relock
        for (int v = 2; v <= 7; v++) smp(v, 1, 0, 0, 0, 0, 0, 1);
        smp(9,  0, 0, 1, 0, 0, 1, 1);
        smp(10, 0, 0, 0, 0, 0, 1, 1);
        smp(11, 0, 0, 0, 0, 0, 1, 1);
        smp(12, 1, 0, 0, 0, 0, 1, 1);
        smp(13, 1, 0, 0, 0, 0, 1, 1);
        // repeated value: err when locked, silent in ACQ
        smp(13, 0, 0, 1, 0, 0, 2, 1);
        smp(13, 0, 0, 0, 0, 0, 2, 1);
        // direction change mid-acquisition restarts it
        smp(12, 0, 1, 0, 0, 0, 2, 1);
        smp(13, 0, 1, 0, 0, 0, 2, 1);
        smp(12, 0, 1, 0, 0, 0, 2, 1);
        smp(11, 0, 1, 0, 0, 0, 2, 1);
        smp(10, 1, 1, 0, 0, 0, 2, 1);
        for (int v = 9; v >= 1; v--) smp(v, 1, 1, 0, 0, 0, 2, 1);
        // clear beats the same-cycle period increment
        drv(1'b0, 1'b1, 1'b1, 0, 1, -1, 0, 0, 1, 0, 0);
        smp(1, 1, 0, 0, 0, 0, 0, 0);

        // reset while locked, then a fresh acquisition from HUNT
        drv(1'b1, 1'b1, 1'b0, 2, 0, 0, 0, 0, 0, 0, 0);
        gap(7, 0, 0, 0, 0);
        smp(5, 0, 0, 0, 0, 0, 0, 0);
        smp(6, 0, 0, 0, 0, 0, 0, 0);
        smp(7, 0, 0, 0, 0, 0, 0, 0);
        smp(8, 1, 0, 0, 0, 0, 0, 0);

        // endpoint reversal accepted during acquisition
        drv(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        smp(13, 0, 0, 0, 0, 0, 0, 0);
        smp(14, 0, 0, 0, 0, 0, 0, 0);
        smp(15, 0, 0, 0, 0, 0, 0, 0);
        smp(14, 1, 1, 0, 0, 0, 0, 0);
        smp(13, 1, 1, 0, 0, 0, 0, 0);

        // 300 lock/mismatch rounds: err_cnt saturates at 255
        for (int i = 1; i <= 300; i++) begin
            int ec;
            ec = (i > 255) ? 255 : i;
            smp(9,  0, -1, 1, 0, 0, ec, 0);
            smp(10, 0, 0, 0, 0, 0, ec, 0);
            smp(11, 0, 0, 0, 0, 0, ec, 0);
            smp(12, 1, 0, 0, 0, 0, ec, 0);
        end

        @(negedge clock);
        en = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
